// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle spawner.
//   state_e      : run-control states (IDLE, RUN, HALT)
//   slot_t       : one obstacle record {valid, lane, voffset}
//   lfsr16_next  : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package obstacle_pkg;

    localparam int unsigned DEF_VWIDTH    = 12;
    localparam int unsigned DEF_LWIDTH    = 2;
    localparam int unsigned DEF_NUM_LANES = 3;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [DEF_LWIDTH-1:0] lane;
        logic [DEF_VWIDTH-1:0] voffset;
    } slot_t;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, advanced one step per cycle while step is high.
//   clk, rst : clock, asynchronous active-high reset (loads SEED)
//   step     : advance enable
//   out      : current LFSR state
module lfsr16
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= SEED;
        end else if (step) begin
            out <= lfsr16_next(out);
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle field generator: a fixed pool of slots that scroll toward the
// player on each frame tick, periodic spawns into pseudo-random lanes,
// off-screen and collision retirement, plus spawn/pass statistics.
//   clk, rst        : clock, asynchronous active-high reset
//   tick            : one-cycle frame strobe
//   start           : begin / restart a run
//   game_over       : freeze the field
//   hit, hit_slot   : collision on a slot, retires it
//   obst_valid/lane/voffset : per-slot field state (invalid slots read 0)
//   running         : high while in RUN
//   spawned_count   : obstacles spawned this run
//   passed_count    : obstacles that scrolled off-screen
module obstacle_spawner
    import obstacle_pkg::*;
#(
    parameter int          VWIDTH      = DEF_VWIDTH,
    parameter int          LWIDTH      = DEF_LWIDTH,
    parameter int          NUM_LANES   = DEF_NUM_LANES,
    parameter int          NUM_SLOTS   = 4,
    parameter int          SPAWN_V     = -64,
    parameter int          END_V       = 480,
    parameter int          STEP        = 4,
    parameter int          SPAWN_TICKS = 30,
    parameter int          COUNT_WIDTH = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tick,
    input  logic                               start,
    input  logic                               game_over,
    input  logic                               hit,
    input  logic [$clog2(NUM_SLOTS)-1:0]       hit_slot,
    output logic [NUM_SLOTS-1:0]               obst_valid,
    output logic [NUM_SLOTS-1:0][LWIDTH-1:0]   obst_lane,
    output logic [NUM_SLOTS-1:0][VWIDTH-1:0]   obst_voffset,
    output logic                               running,
    output logic [COUNT_WIDTH-1:0]             spawned_count,
    output logic [COUNT_WIDTH-1:0]             passed_count
);

    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned TW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

    state_e state_q;
    state_e state_d;
    logic   run_clear;
    logic   active;
    logic   adv;

    // Run control; entering RUN from IDLE or HALT wipes the field.
    always_comb begin
        state_d   = state_q;
        run_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    run_clear = 1'b1;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (start) begin
                    state_d   = RUN;
                    run_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= (state_d == RUN);
        end
    end

    // game_over freezes the field in the same cycle it arrives.
    assign active = (state_q == RUN) && !game_over;
    assign adv    = active && tick;

    logic [15:0] lfsr_q;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (adv),
        .out  (lfsr_q)
    );

    // Lane uses the LFSR value produced by this tick's step.
    logic [LWIDTH-1:0] lane_r;
    logic [LWIDTH-1:0] lane_new;

    always_comb begin
        lane_r   = LWIDTH'(lfsr16_next(lfsr_q));
        lane_new = (32'(lane_r) < 32'(NUM_LANES)) ? lane_r : lane_r - LWIDTH'(NUM_LANES);
    end

    // Lowest-index slot that is free before this cycle's updates.
    logic          free_found;
    logic [SW-1:0] free_idx;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!obst_valid[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    // Spawn timer; holds at its terminal value while the pool is full.
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          spawn_due;
    logic          spawn_go;

    assign spawn_due = adv && (timer_q == TW'(SPAWN_TICKS - 1));
    assign spawn_go  = spawn_due && free_found;

    always_comb begin
        timer_d = timer_q;
        if (run_clear) begin
            timer_d = '0;
        end else if (adv) begin
            if (spawn_due) begin
                if (free_found) begin
                    timer_d = '0;
                end
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    logic [NUM_SLOTS-1:0] retire_pass;

    // Per-slot scroll / retire / spawn.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        slot_t         slot_q;
        slot_t         slot_d;
        logic [VWIDTH:0] sum;
        logic          hit_me;
        logic          move;
        logic          off_end;

        always_comb begin
            hit_me  = active && hit && (hit_slot == SW'(i)) && slot_q.valid;
            move    = adv && slot_q.valid;
            // One extra bit so positions near the top of the range cannot wrap.
            sum     = {slot_q.voffset[VWIDTH-1], slot_q.voffset} + (VWIDTH+1)'(STEP);
            off_end = move && ($signed(sum) > $signed((VWIDTH+1)'(END_V)));

            slot_d = slot_q;
            if (run_clear || hit_me || off_end) begin
                slot_d = '0;
            end else if (move) begin
                slot_d.voffset = sum[VWIDTH-1:0];
            end else if (spawn_go && (free_idx == SW'(i))) begin
                slot_d.valid   = 1'b1;
                slot_d.lane    = lane_new;
                slot_d.voffset = VWIDTH'(SPAWN_V);
            end
        end

        // A hit on a slot that would also scroll off counts as a hit only.
        assign retire_pass[i] = off_end && !hit_me;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign obst_valid[i]   = slot_q.valid;
        assign obst_lane[i]    = slot_q.lane;
        assign obst_voffset[i] = slot_q.voffset;
    end

    logic [COUNT_WIDTH-1:0] n_pass;

    always_comb begin
        n_pass = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n_pass = n_pass + COUNT_WIDTH'(retire_pass[i]);
        end
    end

    // Run statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawned_count <= '0;
            passed_count  <= '0;
        end else if (run_clear) begin
            spawned_count <= '0;
            passed_count  <= '0;
        end else begin
            spawned_count <= spawned_count + COUNT_WIDTH'(spawn_go);
            passed_count  <= passed_count + n_pass;
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: dut_a uses default parameters, dut_b uses a
// one-tick spawn interval. Both are tracked by a behavioural field model.
module tb_obstacle_spawner;

    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             tick_a, start_a, go_a, hit_a;
    logic [1:0]       hs_a;
    logic [NS-1:0]    valid_a;
    logic [NS-1:0][1:0]  lane_a;
    logic [NS-1:0][11:0] voff_a;
    logic             running_a;
    logic [31:0]      sp_a, ps_a;

    logic             tick_b, start_b, go_b, hit_b;
    logic [1:0]       hs_b;
    logic [NS-1:0]    valid_b;
    logic [NS-1:0][1:0]  lane_b;
    logic [NS-1:0][11:0] voff_b;
    logic             running_b;
    logic [31:0]      sp_b, ps_b;

    obstacle_spawner dut_a (
        .clk(clk), .rst(rst), .tick(tick_a), .start(start_a), .game_over(go_a),
        .hit(hit_a), .hit_slot(hs_a), .obst_valid(valid_a), .obst_lane(lane_a),
        .obst_voffset(voff_a), .running(running_a), .spawned_count(sp_a),
        .passed_count(ps_a)
    );

    obstacle_spawner #(.SPAWN_TICKS(1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick_b), .start(start_b), .game_over(go_b),
        .hit(hit_b), .hit_slot(hs_b), .obst_valid(valid_b), .obst_lane(lane_b),
        .obst_voffset(voff_b), .running(running_b), .spawned_count(sp_b),
        .passed_count(ps_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: state 0=idle 1=run 2=halt.
    int m_state [2];
    bit m_v     [2][NS];
    int m_l     [2][NS];
    int m_o     [2][NS];
    int m_sp    [2];
    int m_ps    [2];
    int m_tm    [2];
    int m_lfsr  [2];
    int m_per   [2] = '{30, 1};

    function automatic int lfsr_step(input int x);
        int b;
        b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
        return ((x >> 1) | (b << 15)) & 16'hFFFF;
    endfunction

    function automatic int lane_of(input int x);
        int r;
        r = x & 3;
        return (r < 3) ? r : r - 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_sp[k] = 0; m_ps[k] = 0; m_tm[k] = 0;
            m_lfsr[k] = 16'hACE1;
            for (int s = 0; s < NS; s++) begin
                m_v[k][s] = 0; m_l[k][s] = 0; m_o[k][s] = 0;
            end
        end
    endtask

    task automatic model_step(input int k, input bit tk, input bit st,
                              input bit go, input bit ht, input int hs);
        int free;
        if (m_state[k] == 1) begin
            if (go) begin
                m_state[k] = 2;
            end else begin
                free = -1;
                for (int s = NS - 1; s >= 0; s--) if (!m_v[k][s]) free = s;
                if (ht && m_v[k][hs]) begin
                    m_v[k][hs] = 0; m_l[k][hs] = 0; m_o[k][hs] = 0;
                end
                if (tk) begin
                    m_lfsr[k] = lfsr_step(m_lfsr[k]);
                    for (int s = 0; s < NS; s++) begin
                        if (m_v[k][s]) begin
                            if (m_o[k][s] + 4 > 480) begin
                                m_v[k][s] = 0; m_l[k][s] = 0; m_o[k][s] = 0;
                                m_ps[k]++;
                            end else begin
                                m_o[k][s] += 4;
                            end
                        end
                    end
                    if (m_tm[k] == m_per[k] - 1) begin
                        if (free >= 0) begin
                            m_v[k][free] = 1;
                            m_o[k][free] = -64;
                            m_l[k][free] = lane_of(m_lfsr[k]);
                            m_sp[k]++;
                            m_tm[k] = 0;
                        end
                    end else begin
                        m_tm[k]++;
                    end
                end
            end
        end else if (st) begin
            for (int s = 0; s < NS; s++) begin
                m_v[k][s] = 0; m_l[k][s] = 0; m_o[k][s] = 0;
            end
            m_sp[k] = 0; m_ps[k] = 0; m_tm[k] = 0; m_state[k] = 1;
        end
    endtask

    // One clock: model consumes current inputs, DUT samples them, pulses drop.
    task automatic clk_cycle();
        model_step(0, tick_a, start_a, go_a, hit_a, int'(hs_a));
        model_step(1, tick_b, start_b, go_b, hit_b, int'(hs_b));
        @(posedge clk);
        #1;
        tick_a = 0; start_a = 0; go_a = 0; hit_a = 0;
        tick_b = 0; start_b = 0; go_b = 0; hit_b = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick_a = 0; start_a = 0; go_a = 0; hit_a = 0; hs_a = 0;
        tick_b = 0; start_b = 0; go_b = 0; hit_b = 0; hs_b = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if ({valid_a, running_a, sp_a, ps_a} !== '0 || lane_a !== '0 || voff_a !== '0) begin
            n_fail++;
            $display("FAIL reset_a: valid=%b run=%b sp=%0d ps=%0d, want all zero", valid_a, running_a, sp_a, ps_a);
        end
        n_checks++;
        if ({valid_b, running_b, sp_b, ps_b} !== '0 || lane_b !== '0 || voff_b !== '0) begin
            n_fail++;
            $display("FAIL reset_b: valid=%b run=%b sp=%0d ps=%0d, want all zero", valid_b, running_b, sp_b, ps_b);
        end
        rst = 0;
        tick_a = 1;
        clk_cycle();
        n_checks++;
        if (valid_a !== 4'b0 || running_a !== 1'b0 || sp_a !== 32'd0) begin
            n_fail++;
            $display("FAIL idle_tick: valid=%b run=%b sp=%0d, want 0 0 0", valid_a, running_a, sp_a);
        end
    endtask

    task automatic test_first_spawn();
        start_a = 1;
        clk_cycle();
        n_checks++;
        if (running_a !== 1'b1) begin
            n_fail++;
            $display("FAIL start_running: got %b want 1", running_a);
        end
        for (int t = 1; t <= 30; t++) begin
            repeat ($urandom_range(0, 2)) clk_cycle();
            tick_a = 1;
            clk_cycle();
            if (t < 30) begin
                n_checks++;
                if (valid_a !== 4'b0 || sp_a !== 32'd0) begin
                    n_fail++;
                    $display("FAIL pre_spawn t=%0d: valid=%b sp=%0d want 0 0", t, valid_a, sp_a);
                end
            end
        end
        n_checks++;
        if (valid_a !== 4'b0001 || voff_a[0] !== 12'hFC0 || sp_a !== 32'd1) begin
            n_fail++;
            $display("FAIL first_spawn: valid=%b voff=%0d sp=%0d want 0001 -64 1",
                     valid_a, $signed(voff_a[0]), sp_a);
        end
        n_checks++;
        if (lane_a[0] !== 2'(m_l[0][0])) begin
            n_fail++;
            $display("FAIL first_lane: got %0d want %0d", lane_a[0], m_l[0][0]);
        end
    endtask

    task automatic test_scroll_retire();
        for (int j = 1; j <= 137; j++) begin
            tick_a = 1;
            clk_cycle();
            n_checks++;
            if (j <= 136) begin
                if (valid_a[0] !== 1'b1 || voff_a[0] !== 12'(-64 + 4 * j) || ps_a !== 32'd0) begin
                    n_fail++;
                    $display("FAIL scroll j=%0d: v=%b voff=%0d ps=%0d want 1 %0d 0",
                             j, valid_a[0], $signed(voff_a[0]), ps_a, -64 + 4 * j);
                end
            end else begin
                if (valid_a[0] !== 1'b0 || voff_a[0] !== 12'd0 || ps_a !== 32'd1) begin
                    n_fail++;
                    $display("FAIL retire: v=%b voff=%0d ps=%0d want 0 0 1", valid_a[0], $signed(voff_a[0]), ps_a);
                end
            end
        end
        n_checks++;
        if (valid_a !== 4'b1110 || sp_a !== 32'd4) begin
            n_fail++;
            $display("FAIL after_retire: valid=%b sp=%0d want 1110 4", valid_a, sp_a);
        end
    endtask

    task automatic test_hit();
        hit_a = 1; hs_a = 2;
        clk_cycle();
        n_checks++;
        if (valid_a !== 4'b1010 || ps_a !== 32'd1 || voff_a[2] !== 12'd0 || lane_a[2] !== 2'd0) begin
            n_fail++;
            $display("FAIL hit_valid: valid=%b ps=%0d voff2=%0d want 1010 1 0", valid_a, ps_a, $signed(voff_a[2]));
        end
        hit_a = 1; hs_a = 2;
        clk_cycle();
        n_checks++;
        if (valid_a !== 4'b1010 || ps_a !== 32'd1 || voff_a[1] !== 12'(m_o[0][1])) begin
            n_fail++;
            $display("FAIL hit_empty: valid=%b ps=%0d want 1010 1", valid_a, ps_a);
        end
    endtask

    task automatic test_same_cycle();
        bit found = 0;
        int p0;
        int snap [NS];
        for (int n = 0; n < 300; n++) begin
            if (m_v[0][1] && m_o[0][1] == 480) begin
                found = 1;
                break;
            end
            tick_a = 1;
            clk_cycle();
        end
        n_checks++;
        if (!found || voff_a[1] !== 12'd480) begin
            n_fail++;
            $display("FAIL reach_end: found=%0d voff1=%0d want 480", found, $signed(voff_a[1]));
        end
        p0 = m_ps[0];
        tick_a = 1; hit_a = 1; hs_a = 1;
        clk_cycle();
        n_checks++;
        if (valid_a[1] !== 1'b0 || ps_a !== 32'(p0)) begin
            n_fail++;
            $display("FAIL hit_and_retire: v1=%b ps=%0d want 0 %0d", valid_a[1], ps_a, p0);
        end
        for (int s = 0; s < NS; s++) snap[s] = m_o[0][s];
        go_a = 1; tick_a = 1;
        clk_cycle();
        n_checks++;
        if (running_a !== 1'b0) begin
            n_fail++;
            $display("FAIL go_running: got %b want 0", running_a);
        end
        tick_a = 1;
        clk_cycle();
        for (int s = 0; s < NS; s++) begin
            n_checks++;
            if (voff_a[s] !== 12'(snap[s])) begin
                n_fail++;
                $display("FAIL frozen slot%0d: voff=%0d want %0d", s, $signed(voff_a[s]), snap[s]);
            end
        end
    endtask

    task automatic test_restart();
        start_a = 1;
        clk_cycle();
        n_checks++;
        if (valid_a !== 4'b0 || voff_a !== '0 || sp_a !== 32'd0 || ps_a !== 32'd0 || running_a !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: valid=%b sp=%0d ps=%0d run=%b want 0 0 0 1", valid_a, sp_a, ps_a, running_a);
        end
        repeat (29) begin
            tick_a = 1;
            clk_cycle();
        end
        n_checks++;
        if (sp_a !== 32'd0 || valid_a !== 4'b0) begin
            n_fail++;
            $display("FAIL restart_timer: sp=%0d valid=%b want 0 0", sp_a, valid_a);
        end
        tick_a = 1;
        clk_cycle();
        n_checks++;
        if (sp_a !== 32'd1 || valid_a !== 4'b0001 || lane_a[0] !== 2'(m_l[0][0])) begin
            n_fail++;
            $display("FAIL restart_spawn: sp=%0d valid=%b lane=%0d want 1 0001 %0d", sp_a, valid_a, lane_a[0], m_l[0][0]);
        end
    endtask

    task automatic test_pool_full();
        start_b = 1;
        clk_cycle();
        for (int t = 1; t <= 139; t++) begin
            tick_b = 1;
            clk_cycle();
            n_checks++;
            if (t <= 4) begin
                if (valid_b !== 4'((1 << t) - 1) || sp_b !== 32'(t)) begin
                    n_fail++;
                    $display("FAIL fill t=%0d: valid=%b sp=%0d", t, valid_b, sp_b);
                end
            end else if (t <= 137) begin
                if (valid_b !== 4'hF || sp_b !== 32'd4 || ps_b !== 32'd0) begin
                    n_fail++;
                    $display("FAIL full t=%0d: valid=%b sp=%0d ps=%0d want 1111 4 0", t, valid_b, sp_b, ps_b);
                end
            end else if (t == 138) begin
                if (valid_b !== 4'b1110 || sp_b !== 32'd4 || ps_b !== 32'd1) begin
                    n_fail++;
                    $display("FAIL freed: valid=%b sp=%0d ps=%0d want 1110 4 1", valid_b, sp_b, ps_b);
                end
            end else begin
                if (valid_b !== 4'b1101 || sp_b !== 32'd5 || ps_b !== 32'd2 ||
                    voff_b[0] !== 12'hFC0 || lane_b[0] !== 2'(m_l[1][0])) begin
                    n_fail++;
                    $display("FAIL reuse: valid=%b sp=%0d ps=%0d voff0=%0d want 1101 5 2 -64",
                             valid_b, sp_b, ps_b, $signed(voff_b[0]));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            tick_a  = ($urandom_range(0, 1) == 1);
            hit_a   = ($urandom_range(0, 5) == 0);
            hs_a    = 2'($urandom_range(0, 3));
            start_a = ($urandom_range(0, 59) == 0);
            go_a    = ($urandom_range(0, 249) == 0);
            tick_b  = ($urandom_range(0, 1) == 1);
            hit_b   = ($urandom_range(0, 3) == 0);
            hs_b    = 2'($urandom_range(0, 3));
            start_b = ($urandom_range(0, 59) == 0);
            go_b    = ($urandom_range(0, 249) == 0);
            clk_cycle();
            n_checks++;
            if (running_a !== (m_state[0] == 1) || sp_a !== 32'(m_sp[0]) || ps_a !== 32'(m_ps[0])) begin
                n_fail++;
                $display("FAIL rand_a_ctl c=%0d: run=%b sp=%0d ps=%0d want %0d %0d %0d",
                         c, running_a, sp_a, ps_a, m_state[0] == 1, m_sp[0], m_ps[0]);
            end
            n_checks++;
            if (running_b !== (m_state[1] == 1) || sp_b !== 32'(m_sp[1]) || ps_b !== 32'(m_ps[1])) begin
                n_fail++;
                $display("FAIL rand_b_ctl c=%0d: run=%b sp=%0d ps=%0d want %0d %0d %0d",
                         c, running_b, sp_b, ps_b, m_state[1] == 1, m_sp[1], m_ps[1]);
            end
            for (int s = 0; s < NS; s++) begin
                n_checks++;
                if (valid_a[s] !== m_v[0][s] || lane_a[s] !== 2'(m_l[0][s]) || voff_a[s] !== 12'(m_o[0][s])) begin
                    n_fail++;
                    $display("FAIL rand_a_slot%0d c=%0d: v=%b l=%0d o=%0d want %b %0d %0d", s, c,
                             valid_a[s], lane_a[s], $signed(voff_a[s]), m_v[0][s], m_l[0][s], m_o[0][s]);
                end
                n_checks++;
                if (valid_b[s] !== m_v[1][s] || lane_b[s] !== 2'(m_l[1][s]) || voff_b[s] !== 12'(m_o[1][s])) begin
                    n_fail++;
                    $display("FAIL rand_b_slot%0d c=%0d: v=%b l=%0d o=%0d want %b %0d %0d", s, c,
                             valid_b[s], lane_b[s], $signed(voff_b[s]), m_v[1][s], m_l[1][s], m_o[1][s]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        go_a = 1;
        clk_cycle();
        start_a = 1;
        clk_cycle();
        repeat (40) begin
            tick_a = 1;
            clk_cycle();
        end
        #2;
        rst = 1;
        #1;
        n_checks++;
        if ({valid_a, running_a, sp_a, ps_a} !== '0 || lane_a !== '0 || voff_a !== '0) begin
            n_fail++;
            $display("FAIL async_rst_a: valid=%b run=%b sp=%0d ps=%0d want all zero", valid_a, running_a, sp_a, ps_a);
        end
        n_checks++;
        if ({valid_b, running_b, sp_b, ps_b} !== '0 || lane_b !== '0 || voff_b !== '0) begin
            n_fail++;
            $display("FAIL async_rst_b: valid=%b run=%b sp=%0d ps=%0d want all zero", valid_b, running_b, sp_b, ps_b);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        start_a = 1;
        clk_cycle();
        repeat (30) begin
            tick_a = 1;
            clk_cycle();
        end
        n_checks++;
        if (sp_a !== 32'd1 || valid_a !== 4'b0001 || lane_a[0] !== 2'(m_l[0][0])) begin
            n_fail++;
            $display("FAIL post_rst_spawn: sp=%0d valid=%b lane=%0d want 1 0001 %0d", sp_a, valid_a, lane_a[0], m_l[0][0]);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_scroll_retire();
        test_hit();
        test_same_cycle();
        test_restart();
        test_pool_full();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

- Generates and scrolls the obstacle field that the collision checker consumes.
- Holds a fixed pool of obstacle slots. Each live slot carries a lane and a signed vertical offset.
- On every frame tick, live slots advance toward the player, a new obstacle spawns on a fixed tick interval into a pseudo-random lane, and obstacles that scroll off-screen are retired.
- Collision feedback (hit, hit_slot) retires the struck obstacle. Spawned and passed counts are exported for scoring.

## Interface
- VWIDTH, 12, vertical offset width (signed)
- LWIDTH, 2, lane index width
- NUM_LANES, 3, legal lanes 0..NUM_LANES-1
- NUM_SLOTS, 4, obstacle pool depth
- SPAWN_V, -64, initial voffset of a new obstacle
- END_V, 480, largest voffset a live obstacle may hold
- STEP, 4, voffset increment per tick
- SPAWN_TICKS, 30, ticks between spawn attempts (≥1)
- COUNT_WIDTH, 32, width of statistic counters
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- tick  in  1  one-cycle frame strobe
- start  in  1  one-cycle pulse: begin or restart a run
- game_over  in  1  one-cycle pulse: freeze the field
- hit  in  1  one-cycle pulse: collision on slot hit_slot
- hit_slot  in  $clog2(NUM_SLOTS)  slot index for hit
- obst_valid  out  NUM_SLOTS  per-slot live flag
- obst_lane  out  [NUM_SLOTS] x LWIDTH  per-slot lane
- obst_voffset  out  [NUM_SLOTS] x VWIDTH signed  per-slot vertical offset
- running  out  1  high in RUN
- spawned_count  out  COUNT_WIDTH  obstacles spawned this run
- passed_count  out  COUNT_WIDTH  obstacles retired off-screen (not hit)

## Operation
- **States:** IDLE, RUN, HALT. Reset enters IDLE.
- **IDLE:** the field is empty and ticks are ignored. `start` moves to RUN.
- **RUN:** `game_over` moves to HALT. `start` while already in RUN is ignored.
- **HALT:** slots, counters and LFSR are frozen. `start` clears every slot, zeroes both counters and the spawn timer, then moves to RUN; the LFSR is not reseeded.
- **Per-tick update in RUN:**
  - Each valid slot computes v+STEP in VWIDTH+1 bits.
  - If the result is greater than END_V, the slot is cleared and passed_count increments by one per slot retired.
  - Otherwise the slot takes the truncated result.
- **Spawn timer:**
  - Increments on each tick in RUN.
  - When it reaches SPAWN_TICKS-1 on a tick, it attempts a spawn.
  - A spawn takes the lowest-index slot that was invalid before this cycle: valid=1, voffset=SPAWN_V, lane chosen from the LFSR. spawned_count increments and the timer returns to 0.
  - If no slot is free, the timer holds at SPAWN_TICKS-1 and the spawn retries on the next tick.
- **Lane selection:**
  - r = lfsr[LWIDTH-1:0]; lane = r if r < NUM_LANES, else r - NUM_LANES.
  - The LFSR is 16-bit Fibonacci, taps 16,14,13,11. It steps once per tick in RUN.
- **hit:**
  - Honoured only in RUN and only if the slot is valid; otherwise ignored.
  - Clears the slot. passed_count is not incremented.
- **Simultaneous events:**
  - hit and off-screen retire on the same slot in the same cycle: treated as a hit, no passed increment.
  - game_over and tick in the same cycle: game_over wins and no movement occurs.
  - A slot freed this cycle is not reused until the next spawn attempt.

## Timing
- All outputs are registered and reflect a tick, start, or hit one clk after the input is sampled.
- **Reset values:**
  - obst_valid = 0, obst_lane = 0, obst_voffset = 0.
  - running = 0, both counters = 0, spawn timer = 0, LFSR = LFSR_SEED.
- Reset asserted mid-run clears everything asynchronously and returns to IDLE.
- Consumers may sample outputs any cycle; between ticks they are stable.
- Invalid slots drive lane 0 and voffset 0.

## Structure
- **Package obstacle_pkg:**
  - state enum (IDLE, RUN, HALT).
  - slot struct {valid, lane, voffset}.
  - default lane count and LFSR tap constant.
- **Sub-module lfsr16:**
  - Ports: clk, rst, step, seed parameter, out[15:0].
  - Instantiated once.
- Slot update is a generate loop over NUM_SLOTS. The free-slot priority encoder is combinational in the top level.

## Test plan
- **Reset, then start, then 30 ticks:** on the tick after the 30th, slot 0 is valid with voffset -64 and lane equal to the lane rule applied to the stepped LFSR; spawned_count=1.
- **Scroll and retire:** one obstacle, no hits, 136 ticks after spawn → voffset reaches 480 at tick 136; tick 137 clears it and passed_count=1.
- **Pool full:** SPAWN_TICKS=1, no hits → slots 0..3 fill on ticks 1..4; the 5th tick does not spawn; spawned_count stays 4 until a slot retires, after which the next tick spawns into that slot.
- **hit on slot 2 while valid:** slot 2 is cleared next clk and passed_count is unchanged. hit on an empty slot causes no change.
- **Same-cycle events:** hit on the same slot in the cycle its tick would retire it → cleared with passed_count unchanged. game_over together with tick → voffsets unchanged and running=0.
- **Restart and reset:** start in HALT → all slots invalid, counters 0, running=1. rst asserted mid-run between clk edges → outputs at reset values immediately.
